// File: rtl/tone_gen_pkg.sv
// tone_gen_pkg: shared state encoding and sizing constants for the tone generator.
package tone_gen_pkg;

    localparam int NOTE_W_DEF   = 27;
    localparam int MIN_HALF_DEF = 2;

    typedef enum logic {
        SILENT = 1'b0,
        TONE   = 1'b1
    } state_t;

endpackage

// File: rtl/tone_gen_half_period_counter.sv
// half_period_counter: free-running counter that wraps at limit-1 and flags the terminal count.
module half_period_counter #(
    parameter int W = 27
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic [W-1:0] limit,
    output logic         tc
);

    logic [W-1:0] cnt;

    assign tc = cnt == limit - W'(1);

    always_ff @(posedge clk) begin
        cnt <= (reset || clear || tc) ? '0 : cnt + W'(1);
    end

endmodule

// File: rtl/tone_gen.sv
// tone_gen: square-wave tone player; note changes and mutes only take effect at a falling toggle.
module tone_gen
    import tone_gen_pkg::*;
#(
    parameter int NOTE_W   = NOTE_W_DEF,
    parameter int MIN_HALF = MIN_HALF_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NOTE_W-1:0] note,
    input  logic              enable,
    output logic              audio_out,
    output logic              playing,
    output logic              note_load
);

    state_t            state;
    logic [NOTE_W-1:0] act_note;
    logic [NOTE_W-1:0] req;
    logic              tc;

    assign req     = (note == '0) ? '0 : (note < NOTE_W'(MIN_HALF)) ? NOTE_W'(MIN_HALF) : note;
    assign playing = state == TONE;

    half_period_counter #(.W(NOTE_W)) u_counter (
        .clk   (clk),
        .reset (reset),
        .clear (state == SILENT),
        .limit (act_note),
        .tc    (tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SILENT;
            act_note  <= '0;
            audio_out <= 1'b0;
            note_load <= 1'b0;
        end else begin
            note_load <= 1'b0;
            if (state == SILENT) begin
                if (enable && req != '0) begin
                    state     <= TONE;
                    act_note  <= req;
                    note_load <= 1'b1;
                end
            end else if (tc) begin
                audio_out <= ~audio_out;
                // mute outranks a pending note change at the falling toggle
                if (audio_out) begin
                    if (!enable || req == '0) begin
                        state <= SILENT;
                    end else if (req != act_note) begin
                        act_note  <= req;
                        note_load <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tone_gen.sv
// tb_tone_gen: hand vector table, scenario sequences and randomized run against a timeline model.
module tb_tone_gen;

    localparam int MIN_HALF = 2;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [26:0] note;
    logic        audio_out;
    logic        playing;
    logic        note_load;

    int checks = 0;
    int errors = 0;

    int   t = 0;
    logic m_on = 1'b0;
    logic m_ld = 1'b0;
    int   m_start = 0;
    int   m_half = 0;
    int   loads = 0;

    typedef struct {
        logic        r;
        logic        e;
        logic [26:0] n;
        logic        a;
        logic        p;
        logic        l;
    } vec_t;

    vec_t vecs[$];

    tone_gen dut (
        .clk       (clk),
        .reset     (reset),
        .note      (note),
        .enable    (enable),
        .audio_out (audio_out),
        .playing   (playing),
        .note_load (note_load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int req_of(input logic [26:0] n);
        return (n == 0) ? 0 : (n < MIN_HALF) ? MIN_HALF : int'(n);
    endfunction

    function automatic logic exp_audio();
        return m_on && ((t - m_start) >= m_half);
    endfunction

    // Timeline model: a tone is a start time plus a half-period; decisions only at each full period end.
    task automatic model_edge();
        int rq;
        rq = req_of(note);
        t++;
        m_ld = 1'b0;
        if (reset) begin
            m_on = 1'b0;
        end else if (!m_on) begin
            if (enable && rq != 0) begin
                m_on = 1'b1; m_start = t; m_half = rq; m_ld = 1'b1;
            end
        end else if (t - m_start == 2 * m_half) begin
            m_start = t;
            if (!enable || rq == 0) m_on = 1'b0;
            else if (rq != m_half) begin
                m_half = rq; m_ld = 1'b1;
            end
        end
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %b want %b", name, t, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [26:0] n);
        reset = r; enable = e; note = n;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (note_load === 1'b1) loads++;
    endtask

    task automatic step_model(input logic r, input logic e, input logic [26:0] n);
        step(r, e, n);
        chk("audio_out", audio_out, exp_audio());
        chk("playing", playing, m_on);
        chk("note_load", note_load, m_ld);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; note = '0;
        // {reset, enable, note, audio_out, playing, note_load} after each edge
        vecs.push_back('{1, 1, 1, 0, 0, 0});
        vecs.push_back('{0, 1, 1, 0, 1, 1});
        vecs.push_back('{0, 1, 1, 0, 1, 0});
        vecs.push_back('{0, 1, 1, 1, 1, 0});
        vecs.push_back('{0, 1, 1, 1, 1, 0});
        vecs.push_back('{0, 1, 1, 0, 1, 0});
        vecs.push_back('{0, 1, 1, 0, 1, 0});
        vecs.push_back('{0, 1, 1, 1, 1, 0});
        vecs.push_back('{0, 1, 0, 1, 1, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 3, 0, 1, 1});
        vecs.push_back('{0, 1, 3, 0, 1, 0});
        vecs.push_back('{0, 1, 3, 0, 1, 0});
        vecs.push_back('{0, 1, 3, 1, 1, 0});
        vecs.push_back('{1, 1, 3, 0, 0, 0});
        vecs.push_back('{0, 0, 3, 0, 0, 0});
        vecs.push_back('{0, 1, 3, 0, 1, 1});
        @(negedge clk);
        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].e, vecs[i].n);
            chk($sformatf("vec%0d_audio", i), audio_out, vecs[i].a);
            chk($sformatf("vec%0d_playing", i), playing, vecs[i].p);
            chk($sformatf("vec%0d_load", i), note_load, vecs[i].l);
        end

        // note 4 -> 6 during the high phase: one extra load, then 12-cycle periods
        step_model(1, 1, 4);
        for (int i = 0; i < 5; i++) step_model(0, 1, 4);
        chk("s2_high_before_change", audio_out, 1'b1);
        loads = 0;
        for (int i = 0; i < 40; i++) step_model(0, 1, 6);
        checks++;
        if (loads != 1) begin
            errors++;
            $display("FAIL s2_load_count: got %0d want 1", loads);
        end

        // rest from reset never leaves SILENT
        step_model(1, 1, 0);
        for (int i = 0; i < 10; i++) step_model(0, 1, 0);

        // enable glitch inside a period is inaudible, held low across a fall mutes
        step_model(1, 1, 4);
        for (int i = 0; i < 5; i++) step_model(0, 1, 4);
        step_model(0, 0, 4);
        step_model(0, 0, 4);
        for (int i = 0; i < 12; i++) step_model(0, 1, 4);
        for (int i = 0; i < 14; i++) step_model(0, 0, 4);
        chk("s6_muted", playing, 1'b0);

        // randomized run
        for (int i = 0; i < 4000; i++) begin
            logic        r, e;
            logic [26:0] n;
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 9) != 0) ? 1'b1 : (($urandom_range(0, 3) == 0) ? enable : 1'b0);
            n = note;
            if ($urandom_range(0, 15) == 0)
                n = ($urandom_range(0, 5) == 0) ? 27'd0 : 27'($urandom_range(1, 9));
            step_model(r, e, n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
